// File: rtl/axi4_lite_slave_read.sv
// AXI4-Lite read-channel responder backed by a word-addressed memory.
// Fixed-latency reads; a separate synchronous port loads the memory contents.
module axi4_lite_slave_read #(
    parameter int                          AXI_ADDR_WIDTH = 64,
    parameter int                          AXI_DATA_WIDTH = 32,
    parameter int                          MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter int                          READ_LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]   i_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0]      i_wr_data,
    input  logic                           AR_VALID,
    input  logic [AXI_ADDR_WIDTH-1:0]      AR_ADDR,
    input  logic [2:0]                     AR_PROT,
    output logic                           AR_READY,
    output logic                           R_VALID,
    output logic [AXI_DATA_WIDTH-1:0]      R_DATA,
    output logic [1:0]                     R_RESP,
    input  logic                           R_READY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN_BYTES = AXI_ADDR_WIDTH'(longint'(MEM_DEPTH) * 4);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                     state_reg;
    logic [CNT_W-1:0]           count_reg;
    logic [IDX_W-1:0]           index_reg;
    logic [1:0]                 code_reg;
    logic                       r_valid_reg;
    logic [AXI_DATA_WIDTH-1:0]  r_data_reg;
    logic [1:0]                 r_resp_reg;

    logic [AXI_DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic [AXI_ADDR_WIDTH-1:0]  offset;
    logic                       dec_err;
    logic                       slv_err;
    logic [1:0]                 code_next;
    logic [IDX_W-1:0]           index_next;
    logic                       unused_prot;

    assign unused_prot = ^AR_PROT;

    // Full-width subtraction: addresses below BASE_ADDR wrap, so they are
    // rejected explicitly rather than relying on the range test.
    assign offset  = AR_ADDR - BASE_ADDR;
    assign dec_err = (AR_ADDR < BASE_ADDR) || (offset >= SPAN_BYTES);
    assign slv_err = (AR_ADDR[1:0] != 2'b00);

    always_comb begin
        code_next  = RESP_OKAY;
        index_next = offset[IDX_W+1:2];
        if (dec_err) begin
            code_next = RESP_DECERR;
        end else if (slv_err) begin
            code_next = RESP_SLVERR;
        end
    end

    assign AR_READY = (state_reg == IDLE) && !rst;
    assign R_VALID  = r_valid_reg;
    assign R_DATA   = r_data_reg;
    assign R_RESP   = r_resp_reg;

    // Load port is deliberately outside the reset domain of the FSM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            index_reg   <= '0;
            code_reg    <= RESP_OKAY;
            r_valid_reg <= 1'b0;
            r_data_reg  <= '0;
            r_resp_reg  <= RESP_OKAY;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (AR_VALID) begin
                        index_reg <= index_next;
                        code_reg  <= code_next;
                        count_reg <= CNT_LOAD;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (count_reg == '0) begin
                        // Memory read here sees the pre-edge contents, so a
                        // same-edge load returns the old word.
                        state_reg   <= RESP;
                        r_valid_reg <= 1'b1;
                        r_resp_reg  <= code_reg;
                        r_data_reg  <= (code_reg == RESP_OKAY) ? mem[index_reg] : '0;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (R_READY) begin
                        r_valid_reg <= 1'b0;
                        r_data_reg  <= '0;
                        r_resp_reg  <= RESP_OKAY;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_read.sv
// Bench for axi4_lite_slave_read: directed cases plus randomized reads
// compared against an address-decode and memory-image reference model.
module tb_axi4_lite_slave_read;

    localparam int          AW    = 64;
    localparam int          DW    = 32;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h1000;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 4;

    logic           clk;
    logic           rst;
    logic           i_wr_en;
    logic [7:0]     i_wr_addr;
    logic [DW-1:0]  i_wr_data;
    logic           AR_VALID;
    logic [AW-1:0]  AR_ADDR;
    logic [2:0]     AR_PROT;
    logic           AR_READY;
    logic           R_VALID;
    logic [DW-1:0]  R_DATA;
    logic [1:0]     R_RESP;
    logic           R_READY;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];

    axi4_lite_slave_read #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_DEPTH      (DEPTH),
        .BASE_ADDR      (BASE),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .AR_VALID  (AR_VALID),
        .AR_ADDR   (AR_ADDR),
        .AR_PROT   (AR_PROT),
        .AR_READY  (AR_READY),
        .R_VALID   (R_VALID),
        .R_DATA    (R_DATA),
        .R_RESP    (R_RESP),
        .R_READY   (R_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode: DECERR outside the window, SLVERR if misaligned, else OKAY.
    function automatic logic [1:0] ref_resp(input logic [63:0] a);
        if (a < BASE || (a - BASE) >= SPAN) return 2'b11;
        if (a % 4 != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int ref_index(input logic [63:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic load(input int idx, input logic [31:0] data);
        i_wr_en   = 1'b1;
        i_wr_addr = 8'(idx);
        i_wr_data = data;
        tick();
        i_wr_en   = 1'b0;
        model_mem[idx] = data;
    endtask

    // One read. load_edge: 0 = none, n = load the read word at edge n after
    // the AR handshake (only used for OKAY addresses).
    task automatic do_read(input logic [63:0] addr, input int stall, input int load_edge,
                           input logic [31:0] load_data, input string tag);
        logic [1:0]  er;
        logic [31:0] ed;
        int          idx;
        int          n;
        er  = ref_resp(addr);
        idx = (er == 2'b00) ? ref_index(addr) : 0;
        ed  = (er == 2'b00) ? model_mem[idx] : 32'h0;
        if (er == 2'b00 && load_edge >= 1 && load_edge < LAT) ed = load_data;

        n = 0;
        while (!AR_READY && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_arready_idle"}, AR_READY, 1'b1);

        AR_VALID = 1'b1;
        AR_ADDR  = addr;
        AR_PROT  = 3'($urandom);
        R_READY  = (stall == 0);
        tick();
        AR_VALID = 1'b0;
        AR_ADDR  = {$urandom, $urandom};
        check({tag, "_arready_busy"}, AR_READY, 1'b0);

        n = 0;
        while (!R_VALID && n < 20) begin
            if (er == 2'b00 && n + 1 == load_edge) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 8'(idx);
                i_wr_data = load_data;
            end
            tick();
            i_wr_en = 1'b0;
            n++;
            if (er == 2'b00 && n == load_edge) model_mem[idx] = load_data;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_data"}, R_DATA, ed);
        check({tag, "_resp"}, R_RESP, er);

        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_stall_valid"}, R_VALID, 1'b1);
            check({tag, "_stall_data"}, R_DATA, ed);
            check({tag, "_stall_resp"}, R_RESP, er);
            check({tag, "_stall_arready"}, AR_READY, 1'b0);
        end

        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
        check({tag, "_done_valid"}, R_VALID, 1'b0);
        check({tag, "_done_data"}, R_DATA, 32'h0);
        check({tag, "_done_resp"}, R_RESP, 2'b00);
        check({tag, "_done_arready"}, AR_READY, 1'b1);
        $display("read %s addr=%h resp=%0d data=%h stall=%0d load_edge=%0d",
                 tag, addr, er, ed, stall, load_edge);
    endtask

    initial begin
        logic [63:0] a;
        int          k;
        int          n;
        rst       = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        AR_VALID  = 1'b0;
        AR_ADDR   = '0;
        AR_PROT   = '0;
        R_READY   = 1'b0;

        // Memory loads are accepted while reset is held.
        tick();
        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
        check("rst_arready", AR_READY, 1'b0);
        check("rst_rvalid", R_VALID, 1'b0);
        check("rst_rdata", R_DATA, 32'h0);
        check("rst_rresp", R_RESP, 2'b00);
        rst = 1'b0;
        #1;
        check("post_rst_arready", AR_READY, 1'b1);

        load(5, 32'hDEAD_BEEF);
        do_read(BASE + 64'h14, 0, 0, 0, "basic");
        do_read(BASE + 64'h14, 5, 0, 0, "stall5");
        do_read(BASE + 64'h402, 0, 0, 0, "oob");
        do_read(BASE + 64'h13, 1, 0, 0, "misalign");
        do_read(BASE - 64'h4, 0, 0, 0, "below_base");
        do_read(BASE + 64'h0, 0, 0, 0, "b2b_w0");
        do_read(BASE + 64'h4, 0, 0, 0, "b2b_w1");
        do_read(BASE + 64'h3FC, 0, 0, 0, "b2b_w255");
        do_read(BASE + 64'h20, 0, 1, 32'h1111_1111, "wr_in_wait");
        do_read(BASE + 64'h24, 0, 2, 32'h2222_2222, "wr_at_capture");
        do_read(BASE + 64'h24, 0, 0, 0, "wr_after");

        // Reset during WAIT drops the pending read.
        AR_VALID = 1'b1;
        AR_ADDR  = BASE + 64'h14;
        R_READY  = 1'b1;
        tick();
        AR_VALID = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_arready_during", AR_READY, 1'b0);
        tick();
        check("midrst_rvalid", R_VALID, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_arready_after", AR_READY, 1'b1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (R_VALID) n++;
        end
        check("midrst_no_beat", 64'(n), 64'd0);
        R_READY = 1'b0;
        do_read(BASE + 64'h14, 0, 0, 0, "midrst_reread");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) load($urandom_range(0, DEPTH - 1), $urandom);
            k = $urandom_range(0, 5);
            case (k)
                0, 1, 2: a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 4;
                3:       a = BASE + 64'($urandom_range(0, 32'h7FF));
                4:       a = 64'($urandom_range(0, 32'hFFF));
                default: a = {$urandom, $urandom};
            endcase
            do_read(a, $urandom_range(0, 3),
                    (ref_resp(a) == 2'b00) ? $urandom_range(0, LAT) : 0,
                    $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
